// File: rtl/cell_scheduler.sv
// cell_scheduler: walks every CELL_N x CELL_N cell position of an IMG_W x IMG_H
// image, issuing one request per cell to a cell processor with at most MAX_OUT
// requests in flight, then waits for every result before signalling done.
// Optional feature: define CELL_SCHED_ABORT_EN to add an 'abort' input that
// stops issuing early and drains the requests already in flight.
module cell_scheduler #(
  parameter int IMG_W   = 640,
  parameter int IMG_H   = 480,
  parameter int CELL_N  = 3,
  parameter int MAX_OUT = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
`ifdef CELL_SCHED_ABORT_EN
  input  logic                     abort,
`endif
  input  logic [3:0]               opcode_in,
  input  logic [7:0]               user_in,
  output logic                     req_valid,
  input  logic                     req_ready,
  output logic [$clog2(IMG_H)-1:0] req_row,
  output logic [$clog2(IMG_W)-1:0] req_col,
  output logic [3:0]               req_opcode,
  output logic [7:0]               req_user,
  input  logic                     rsp_valid,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int ROW_W = $clog2(IMG_H);
  localparam int COL_W = $clog2(IMG_W);
  localparam int OUT_W = $clog2(MAX_OUT + 1);

  // Last legal top-left corner in each direction; the cell must fit in the image.
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - CELL_N);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - CELL_N);
  localparam logic [OUT_W-1:0] OUT_MAX  = OUT_W'(MAX_OUT);
  localparam logic [3:0]       OPC_LAST = 4'd11;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } stateT;

  stateT            state;
  logic [OUT_W-1:0] outstanding;
  logic [OUT_W-1:0] outNext;
  logic             xfer;
  logic             rspOk;
  logic             rspBad;
  logic             lastCell;
  logic             abortReq;

`ifdef CELL_SCHED_ABORT_EN
  assign abortReq = abort;
`else
  assign abortReq = 1'b0;
`endif

  // A request is offered only while issuing and a result slot is still free.
  assign req_valid = (state == ISSUE) && (outstanding < OUT_MAX);

  // Transfer/response decode and the next in-flight count; a response with
  // nothing in flight is dropped so the counter can never wrap.
  always_comb begin
    xfer     = req_valid & req_ready;
    rspOk    = rsp_valid && (outstanding != '0);
    rspBad   = rsp_valid && (outstanding == '0);
    lastCell = (req_row == ROW_LAST) && (req_col == COL_LAST);
    outNext  = outstanding;
    if (xfer && !rspOk) begin
      outNext = outstanding + OUT_W'(1);
    end else if (!xfer && rspOk) begin
      outNext = outstanding - OUT_W'(1);
    end
  end

  // Job FSM with the cell cursor, latched operands and registered status flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      req_row     <= '0;
      req_col     <= '0;
      req_opcode  <= '0;
      req_user    <= '0;
      outstanding <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      done        <= 1'b0;
      err         <= rspBad;
      outstanding <= outNext;
      case (state)
        IDLE: begin
          if (start) begin
            if (opcode_in <= OPC_LAST) begin
              req_opcode <= opcode_in;
              req_user   <= user_in;
              req_row    <= '0;
              req_col    <= '0;
              busy       <= 1'b1;
              state      <= ISSUE;
            end else begin
              err <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (xfer) begin
            if (lastCell) begin
              state <= DRAIN;
            end else if (req_col == COL_LAST) begin
              req_col <= '0;
              req_row <= req_row + ROW_W'(1);
            end else begin
              req_col <= req_col + COL_W'(1);
            end
          end
          if (abortReq) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (outNext == '0) begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/cell_scheduler.md
CELL_SCHEDULER -- requirements
Module: cell_scheduler

Interface
REQ-001 The block SHALL have parameter IMG_W, default 640, meaning image width in pixels.
REQ-002 The block SHALL have parameter IMG_H, default 480, meaning image height in pixels.
REQ-003 The block SHALL have parameter CELL_N, default 3, meaning cell edge in pixels.
REQ-004 The block SHALL have parameter MAX_OUT, default 4, meaning the maximum number of outstanding cell requests.
REQ-005 The block SHALL have port clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port start, input, 1 bit: pulse that begins an image job.
REQ-008 The block SHALL have port opcode_in, input, 4 bits: opcodes_t value for the job.
REQ-009 The block SHALL have port user_in, input, 8 bits: immediate operand for the job.
REQ-010 The block SHALL have port req_valid, output, 1 bit: a cell request is presented.
REQ-011 The block SHALL have port req_ready, input, 1 bit: the cell processor accepts the request.
REQ-012 The block SHALL have ports req_row, output, $clog2(IMG_H) bits, and req_col, output, $clog2(IMG_W) bits: top-left pixel of the cell.
REQ-013 The block SHALL have ports req_opcode, output, 4 bits, and req_user, output, 8 bits: the latched job operands.
REQ-014 The block SHALL have port rsp_valid, input, 1 bit: one cell result has been returned.
REQ-015 The block SHALL have ports busy, output, 1 bit; done, output, 1 bit (one-cycle pulse); and err, output, 1 bit (one-cycle pulse).

Function
REQ-016 The FSM SHALL have states IDLE, ISSUE, DRAIN and DONE.
REQ-017 IDLE->ISSUE on start=1 with opcode_in<=11 (AVG): latch opcode_in/user_in, set row=col=0, busy=1 on the next cycle.
REQ-018 A start with opcode_in>=12 in IDLE SHALL be ignored, with err=1 for one cycle.
REQ-019 A start while busy SHALL be ignored without an err pulse.
REQ-020 In ISSUE, req_valid SHALL be 1 whenever outstanding<MAX_OUT; req_row/req_col/req_opcode/req_user SHALL be held stable while req_valid=1 and req_ready=0.
REQ-021 A transfer occurs when req_valid&req_ready=1; after a transfer, col SHALL increment; at col=IMG_W-CELL_N, col SHALL wrap to 0 and row increments.
REQ-022 The transfer of the cell at row=IMG_H-CELL_N, col=IMG_W-CELL_N SHALL move the FSM to DRAIN, with req_valid=0 from the next cycle.
REQ-023 The total issued cells per job SHALL be (IMG_W-CELL_N+1)*(IMG_H-CELL_N+1), i.e. 638*478=304964 at defaults.
REQ-024 The outstanding counter, of width $clog2(MAX_OUT+1), SHALL be incremented on a transfer and decremented on rsp_valid; simultaneous events SHALL leave it unchanged.
REQ-025 rsp_valid with outstanding=0 SHALL be ignored (no underflow) and SHALL pulse err.
REQ-026 DRAIN->DONE when outstanding reaches 0 (including via a same-cycle rsp_valid); DONE SHALL assert done=1 for one cycle, then return to IDLE with busy=0.
REQ-027 busy SHALL be 1 in ISSUE, DRAIN and DONE, and 0 in IDLE.

Reset
REQ-028 reset=1 at a clock edge SHALL force IDLE, with row=col=outstanding=0, req_valid=busy=done=err=0, and req_opcode=req_user=0, regardless of the current state.
REQ-029 Reset mid-job SHALL discard the job; responses arriving afterwards SHALL be treated per REQ-025.

Configuration
REQ-030 With CELL_SCHED_ABORT_EN defined, the block SHALL add input abort (1 bit): in ISSUE, abort=1 SHALL deassert req_valid the next cycle and enter DRAIN; done SHALL still pulse after the drain completes.
REQ-031 Without CELL_SCHED_ABORT_EN, the abort port SHALL be absent and jobs always run to completion.

Verification
REQ-032 IMG_W=5, IMG_H=4, req_ready=1, rsp_valid one cycle after each transfer, start with opcode=ADDI, user=8'h10 -> 6 transfers (row,col) in the order (0,0),(0,1),(0,2),(1,0),(1,1),(1,2), req_user=8'h10 throughout, a single done pulse, then busy=0.
REQ-033 MAX_OUT=2 with rsp_valid withheld -> exactly 2 transfers, then req_valid=0 until a rsp_valid arrives.
REQ-034 req_ready=0 for 3 cycles mid-job -> req_row/req_col remain stable and no cell is skipped.
REQ-035 start with opcode_in=4'd12 -> err pulse, busy stays 0; start during busy -> ignored and the job is unaffected.
REQ-036 reset asserted in ISSUE after 2 transfers -> next cycle IDLE, all outputs 0; a following start runs a full 6-cell job.
REQ-037 With CELL_SCHED_ABORT_EN defined: abort after 3 transfers with 1 outstanding -> no further transfers, and done follows the last rsp_valid.
